// File: rtl/gravacao_player.sv
// Record/playback byte buffer: captures a valid/ready stream into a DEPTH-entry memory and replays it in order.
// Optional GRAVACAO_LOOP_EN: playback wraps to entry 0 forever instead of ending with a done pulse.
module gravacao_player #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_rec,
    input  logic          cmd_play,
    input  logic          cmd_stop,
    input  logic          rec_valid,
    output logic          rec_ready,
    input  logic [DW-1:0] rec_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   len,
    output logic          full,
    output logic          overflow,
    output logic          done,
    output logic          busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_REC, ST_PLAY} state_t;

    localparam logic [AW:0] LEN_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];

    state_t        r_state, w_state_next;
    logic [AW:0]   r_len, w_len_next, w_len_wr;
    logic [AW-1:0] r_rd_ptr, w_rd_ptr_next, w_rd_addr;
    logic [DW-1:0] r_out_data, w_rd_data;
    logic          r_out_valid, w_out_valid_next;
    logic          r_overflow, w_overflow_next;
    logic          r_done, w_done_next;
    logic          w_rec_ready, w_wr_en, w_rd_en, w_last;

    assign w_rec_ready = (r_state == ST_REC) && (r_len < LEN_FULL);
    assign w_wr_en     = w_rec_ready && rec_valid;
    assign w_len_wr    = w_wr_en ? r_len + (AW+1)'(1) : r_len;
    assign w_last      = ({1'b0, r_rd_ptr} == r_len - (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_len[AW-1:0]] <= rec_data;
        end
    end

    // A play strobe coinciding with the very first write must see the byte being written.
    assign w_rd_data = (w_wr_en && (w_rd_addr == r_len[AW-1:0])) ? rec_data : r_mem[w_rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_len_next       = r_len;
        w_rd_ptr_next    = r_rd_ptr;
        w_out_valid_next = r_out_valid;
        w_overflow_next  = r_overflow;
        w_done_next      = 1'b0;
        w_rd_en          = 1'b0;
        w_rd_addr        = '0;
        case (r_state)
            ST_IDLE: begin
                w_out_valid_next = 1'b0;
                if (cmd_stop) begin
                    w_state_next = ST_IDLE;
                end else if (cmd_rec) begin
                    w_state_next    = ST_REC;
                    w_len_next      = '0;
                    w_overflow_next = 1'b0;
                end else if (cmd_play && (r_len != '0)) begin
                    w_state_next     = ST_PLAY;
                    w_rd_ptr_next    = '0;
                    w_rd_en          = 1'b1;
                    w_out_valid_next = 1'b1;
                end
            end
            ST_REC: begin
                w_out_valid_next = 1'b0;
                w_len_next       = w_len_wr;
                if (rec_valid && !w_rec_ready) begin
                    w_overflow_next = 1'b1;
                end
                // Commands act on the length after this cycle's write.
                if (cmd_stop) begin
                    w_state_next = ST_IDLE;
                end else if (cmd_rec) begin
                    w_len_next      = '0;
                    w_overflow_next = 1'b0;
                end else if (cmd_play && (w_len_wr != '0)) begin
                    w_state_next     = ST_PLAY;
                    w_rd_ptr_next    = '0;
                    w_rd_en          = 1'b1;
                    w_out_valid_next = 1'b1;
                end
            end
            ST_PLAY: begin
                if (cmd_stop) begin
                    w_state_next     = ST_IDLE;
                    w_out_valid_next = 1'b0;
                end else if (cmd_rec) begin
                    w_state_next     = ST_REC;
                    w_len_next       = '0;
                    w_overflow_next  = 1'b0;
                    w_out_valid_next = 1'b0;
                end else if (cmd_play) begin
                    w_rd_ptr_next    = '0;
                    w_rd_en          = 1'b1;
                    w_out_valid_next = 1'b1;
                end else if (r_out_valid && out_ready) begin
                    if (!w_last) begin
                        w_rd_ptr_next = r_rd_ptr + AW'(1);
                        w_rd_addr     = r_rd_ptr + AW'(1);
                        w_rd_en       = 1'b1;
                    end else begin
`ifdef GRAVACAO_LOOP_EN
                        w_rd_ptr_next = '0;
                        w_rd_en       = 1'b1;
`else
                        w_out_valid_next = 1'b0;
                        w_done_next      = 1'b1;
                        w_state_next     = ST_IDLE;
`endif
                    end
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len       <= '0;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_len       <= w_len_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_out_valid <= w_out_valid_next;
            r_overflow  <= w_overflow_next;
            r_done      <= w_done_next;
            if (w_rd_en) begin
                r_out_data <= w_rd_data;
            end
        end
    end

    assign rec_ready = w_rec_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign len       = r_len;
    assign full      = (r_len == LEN_FULL);
    assign overflow  = r_overflow;
    assign done      = r_done;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gravacao_player.sv
// Self-checking bench for gravacao_player: directed scenarios plus randomized rounds against a queue model.
module tb_gravacao_player;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;
`ifdef GRAVACAO_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_rec, cmd_play, cmd_stop;
    logic          rec_valid, rec_ready;
    logic [DW-1:0] rec_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   len;
    logic          full, overflow, done, busy;

    int checks = 0;
    int errors = 0;

    // Reference model: the recorded bytes in order, plus the sticky overflow bit.
    logic [DW-1:0] q [$];
    bit            m_ovf;

    gravacao_player #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_rec(cmd_rec), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_data(rec_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .len(len), .full(full), .overflow(overflow), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rec();
        cmd_rec = 1'b1; tick(); cmd_rec = 1'b0;
        q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    endtask

    task automatic rec_byte(input logic [DW-1:0] b);
        rec_valid = 1'b1;
        rec_data  = b;
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovf = 1'b1;
        tick();
        rec_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_rec = 0; cmd_play = 0; cmd_stop = 0;
        rec_valid = 0; rec_data = '0; out_ready = 0;
        #3;
        checks++;
        if ({out_valid, rec_ready, full, overflow, done, busy} !== 6'b0 || len !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b full=%b ovf=%b done=%b busy=%b len=%0d data=%h, required all zero",
                     out_valid, rec_ready, full, overflow, done, busy, len, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || len !== '0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b len=%0d, required 0 0", busy, len);
        end
        q.delete();
        m_ovf = 1'b0;
    endtask

    // Plays back the model contents and checks order, backpressure stability and completion.
    task automatic test_playback(input int ready_pct, input int stall_first, input bit start, input string tag);
        int idx = 0;
        int budget = 0;
        int stalls = 0;
        if (start) begin
            cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        end
        while (idx < q.size() && budget < 2000) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (idx == 0 && stalls < stall_first) begin
                out_ready = 1'b0;
                stalls++;
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== q[idx]) begin
                errors++;
                $display("FAIL %s_data[%0d]: got valid=%b data=%h, required valid=1 data=%h", tag, idx, out_valid, out_data, q[idx]);
            end
            tick();
            if (out_ready) begin
                $display("[%s] play byte %0d = 0x%02h", tag, idx, q[idx]);
                idx++;
            end
            budget++;
        end
        checks++;
        if (budget >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d of %0d bytes, required all", tag, idx, q.size());
        end
        out_ready = 1'b1;
        checks++;
        if (done !== !LOOP || out_valid !== LOOP || busy !== LOOP) begin
            errors++;
            $display("FAIL %s_end: got done=%b valid=%b busy=%b, required done=%b valid=%b busy=%b",
                     tag, done, out_valid, busy, !LOOP, LOOP, LOOP);
        end
        if (LOOP) begin
            checks++;
            if (out_data !== q[0]) begin
                errors++;
                $display("FAIL %s_wrap: got %h, required %h", tag, out_data, q[0]);
            end
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: got done=%b one cycle later, required 0", tag, done);
        end
        pulse_stop();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || len !== (AW+1)'(q.size())) begin
            errors++;
            $display("FAIL %s_after_stop: got valid=%b busy=%b len=%0d, required 0 0 %0d", tag, out_valid, busy, len, q.size());
        end
    endtask

    task automatic test_basic();
        pulse_rec();
        checks++;
        if (busy !== 1'b1 || rec_ready !== 1'b1 || len !== '0) begin
            errors++;
            $display("FAIL basic_rec_entry: got busy=%b ready=%b len=%0d, required 1 1 0", busy, rec_ready, len);
        end
        rec_byte(8'h11); rec_byte(8'h22); rec_byte(8'h33);
        pulse_stop();
        checks++;
        if (len !== 5'd3 || full !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_len: got len=%0d full=%b busy=%b ovf=%b, required 3 0 0 0", len, full, busy, overflow);
        end
        test_playback(100, 0, 1'b1, "basic");
    endtask

    task automatic test_overflow();
        pulse_rec();
        for (int i = 0; i < DEPTH + 1; i++) begin
            rec_valid = 1'b1;
            rec_data  = DW'(i);
            checks++;
            if (rec_ready !== (q.size() < DEPTH)) begin
                errors++;
                $display("FAIL ovf_ready[%0d]: got %b, required %b", i, rec_ready, q.size() < DEPTH);
            end
            if (q.size() < DEPTH) q.push_back(DW'(i));
            else m_ovf = 1'b1;
            tick();
        end
        rec_valid = 1'b0;
        checks++;
        if (len !== (AW+1)'(DEPTH) || full !== 1'b1 || overflow !== m_ovf || rec_ready !== 1'b0) begin
            errors++;
            $display("FAIL ovf_flags: got len=%0d full=%b ovf=%b ready=%b, required %0d 1 %b 0", len, full, overflow, rec_ready, DEPTH, m_ovf);
        end
        pulse_stop();
        test_playback(100, 0, 1'b1, "ovf");
    endtask

    task automatic test_backpressure();
        pulse_rec();
        rec_byte(8'hA1); rec_byte(8'hB2);
        pulse_stop();
        test_playback(100, 3, 1'b1, "bp");
    endtask

    task automatic test_empty_priority();
        pulse_rec();
        pulse_stop();
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_play: got valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        cmd_rec = 1'b1; cmd_stop = 1'b1; tick(); cmd_rec = 1'b0; cmd_stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_stop_over_rec: got busy=%b, required 0", busy);
        end
        pulse_rec();
        rec_byte(8'h5C);
        pulse_stop();
        cmd_rec = 1'b1; cmd_play = 1'b1; tick(); cmd_rec = 1'b0; cmd_play = 1'b0;
        q.delete();
        checks++;
        if (busy !== 1'b1 || rec_ready !== 1'b1 || len !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_rec_over_play: got busy=%b ready=%b len=%0d valid=%b, required 1 1 0 0", busy, rec_ready, len, out_valid);
        end
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        pulse_rec();
        for (int i = 0; i < 4; i++) rec_byte(DW'($urandom));
        pulse_stop();
        out_ready = 1'b1;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== q[1]) begin
            errors++;
            $display("FAIL rstmid_second: got valid=%b data=%h, required 1 %h", out_valid, out_data, q[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || len !== '0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got valid=%b len=%0d busy=%b data=%h, required 0 0 0 00", out_valid, len, busy, out_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_play_ignored: got valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int n = $urandom_range(1, 22);
            bit play_direct = $urandom_range(0, 1);
            pulse_rec();
            for (int k = 0; k < n; k++) begin
                while ($urandom_range(0, 3) == 0) begin
                    rec_valid = 1'b0;
                    checks++;
                    if (rec_ready !== (q.size() < DEPTH) || len !== (AW+1)'(q.size())) begin
                        errors++;
                        $display("FAIL rnd%0d_idle: got ready=%b len=%0d, required %b %0d", r, rec_ready, len, q.size() < DEPTH, q.size());
                    end
                    tick();
                end
                checks++;
                if (rec_ready !== (q.size() < DEPTH) || len !== (AW+1)'(q.size())) begin
                    errors++;
                    $display("FAIL rnd%0d_rec: got ready=%b len=%0d, required %b %0d", r, rec_ready, len, q.size() < DEPTH, q.size());
                end
                if (k == n - 1) begin
                    if (play_direct) cmd_play = 1'b1;
                    else cmd_stop = 1'b1;
                end
                rec_byte(DW'($urandom));
                cmd_play = 1'b0;
                cmd_stop = 1'b0;
            end
            checks++;
            if (overflow !== m_ovf || full !== (q.size() == DEPTH)) begin
                errors++;
                $display("FAIL rnd%0d_flags: got ovf=%b full=%b, required %b %b", r, overflow, full, m_ovf, q.size() == DEPTH);
            end
            test_playback(70, 0, !play_direct, $sformatf("rnd%0d", r));
        end
    endtask

`ifdef GRAVACAO_LOOP_EN
    task automatic test_loop();
        pulse_rec();
        rec_byte(8'hA5); rec_byte(8'h5A);
        pulse_stop();
        out_ready = 1'b1;
        cmd_play = 1'b1; tick(); cmd_play = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== q[i % 2] || done !== 1'b0) begin
                errors++;
                $display("FAIL loop[%0d]: got valid=%b data=%h done=%b, required 1 %h 0", i, out_valid, out_data, done, q[i % 2]);
            end
            $display("[loop] play byte %0d = 0x%02h", i, q[i % 2]);
            tick();
        end
        pulse_stop();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop: got valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_empty_priority();
        test_reset_mid();
        test_random();
`ifdef GRAVACAO_LOOP_EN
        test_loop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
